// File: rtl/trap_redirect_seq.sv
// Trap/mret redirect sequencer: flushes the pipe, stalls fetch, then issues a one-cycle PC redirect.
// Optional vectored interrupt targets are enabled with `define TRAP_VECTORED_EN.

`ifndef NO_E
`define NO_E 4'hF
`endif

module trap_redirect_seq #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clk_en,
  input  logic [3:0]      i_exception_code_f_d_ff,
  input  logic [3:0]      i_exception_code_e_m_ff,
  input  logic            i_mret_e,
  input  logic            i_irq_ext,
  input  logic [PC_W-1:0] i_mtvec,
  input  logic [PC_W-1:0] i_mepc,
  input  logic [PC_W-1:0] i_mie,
  input  logic [PC_W-1:0] i_mstatus_lower,
  output logic            o_flush_f_d,
  output logic            o_flush_d_e,
  output logic            o_flush_e_m,
  output logic            o_stall_f,
  output logic            o_redirect_valid,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic            o_trap_taken,
  output logic            o_irq_ack,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [PC_W-1:0] target_r;
  logic            flush_f_d_r;
  logic            flush_d_e_r;
  logic            flush_e_m_r;
  logic            stall_f_r;
  logic            redirect_valid_r;
  logic [PC_W-1:0] redirect_pc_r;
  logic            trap_taken_r;
  logic            irq_ack_r;
  logic            busy_r;

  logic            exc_s;
  logic            mret_s;
  logic            irq_s;
  logic            event_s;
  logic [PC_W-1:0] base_s;
  logic [PC_W-1:0] target_next_s;
  logic            unused_s;

  assign unused_s = ^{i_mie, i_mstatus_lower, i_mtvec[1:0]};

  // Event decode with priority: exceptions, then mret, then the gated interrupt.
  always_comb begin
    exc_s         = 1'b0;
    mret_s        = 1'b0;
    irq_s         = 1'b0;
    event_s       = 1'b0;
    base_s        = {i_mtvec[PC_W-1:2], 2'b00};
    target_next_s = base_s;
    if ((i_exception_code_e_m_ff != `NO_E) || (i_exception_code_f_d_ff != `NO_E)) begin
      exc_s = 1'b1;
    end else if (i_mret_e) begin
      mret_s = 1'b1;
    end else begin
      irq_s = i_irq_ext & i_mie[11] & i_mstatus_lower[3];
    end
    event_s = exc_s | mret_s | irq_s;
    if (mret_s) begin
      target_next_s = i_mepc;
`ifdef TRAP_VECTORED_EN
    end else if (irq_s && (i_mtvec[1:0] == 2'b01)) begin
      // External interrupt cause 11, four bytes per vector slot.
      target_next_s = base_s + PC_W'(6'd44);
`endif
    end else begin
      target_next_s = base_s;
    end
  end

  // Sequencer FSM with all outputs registered; i_clk_en low freezes everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 4'd0;
      target_r         <= '0;
      flush_f_d_r      <= 1'b0;
      flush_d_e_r      <= 1'b0;
      flush_e_m_r      <= 1'b0;
      stall_f_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      trap_taken_r     <= 1'b0;
      irq_ack_r        <= 1'b0;
      busy_r           <= 1'b0;
    end else if (i_clk_en) begin
      flush_f_d_r      <= 1'b0;
      flush_d_e_r      <= 1'b0;
      flush_e_m_r      <= 1'b0;
      stall_f_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      trap_taken_r     <= 1'b0;
      irq_ack_r        <= 1'b0;
      busy_r           <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (event_s) begin
            state_r      <= ST_DRAIN;
            cnt_r        <= CNT_LOAD;
            target_r     <= target_next_s;
            flush_f_d_r  <= 1'b1;
            flush_d_e_r  <= 1'b1;
            flush_e_m_r  <= 1'b1;
            stall_f_r    <= 1'b1;
            busy_r       <= 1'b1;
            trap_taken_r <= exc_s | irq_s;
            irq_ack_r    <= irq_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (cnt_r == 4'd0) begin
            state_r          <= ST_REDIRECT;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= target_r;
            busy_r           <= 1'b1;
          end else begin
            cnt_r       <= cnt_r - 4'd1;
            flush_f_d_r <= 1'b1;
            flush_d_e_r <= 1'b1;
            flush_e_m_r <= 1'b1;
            stall_f_r   <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign o_flush_f_d      = flush_f_d_r;
  assign o_flush_d_e      = flush_d_e_r;
  assign o_flush_e_m      = flush_e_m_r;
  assign o_stall_f        = stall_f_r;
  assign o_redirect_valid = redirect_valid_r;
  assign o_redirect_pc    = redirect_pc_r;
  assign o_trap_taken     = trap_taken_r;
  assign o_irq_ack        = irq_ack_r;
  assign o_busy           = busy_r;

`ifndef SYNTHESIS
  trap_redirect_seq_chk #(.PC_W(PC_W)) u_chk (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .o_flush_f_d     (o_flush_f_d),
    .o_stall_f       (o_stall_f),
    .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc   (o_redirect_pc),
    .o_trap_taken    (o_trap_taken),
    .o_irq_ack       (o_irq_ack),
    .o_busy          (o_busy)
  );
`endif

endmodule

// Output-relationship properties of the sequencer, kept apart from the datapath.
module trap_redirect_seq_chk #(
  parameter int unsigned PC_W = 32
) (
  input logic            i_clk,
  input logic            i_rst_n,
  input logic            o_flush_f_d,
  input logic            o_stall_f,
  input logic            o_redirect_valid,
  input logic [PC_W-1:0] o_redirect_pc,
  input logic            o_trap_taken,
  input logic            o_irq_ack,
  input logic            o_busy
);

  a_redirect_no_flush: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_redirect_valid |-> (!o_flush_f_d && !o_stall_f));
  a_pc_zero_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !o_redirect_valid |-> (o_redirect_pc == '0));
  a_ack_is_trap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_irq_ack |-> o_trap_taken);
  a_busy_cover: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_flush_f_d || o_redirect_valid) |-> o_busy);

endmodule

// File: tb/tb_trap_redirect_seq.sv
// Randomized bench for trap_redirect_seq against a timeline-queue reference model.

`ifndef NO_E
`define NO_E 4'hF
`endif

module tb_trap_redirect_seq;

  localparam int FC = 2;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic [3:0]    code_fd;
  logic [3:0]    code_em;
  logic          mret;
  logic          irq;
  logic [PW-1:0] mtvec;
  logic [PW-1:0] mepc;
  logic [PW-1:0] mie;
  logic [PW-1:0] mstatus;
  logic          flush_f_d, flush_d_e, flush_e_m, stall_f, rv, trap, ack, busy;
  logic [PW-1:0] rpc;

  trap_redirect_seq #(.FLUSH_CYCLES(FC), .PC_W(PW)) dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_clk_en               (clk_en),
    .i_exception_code_f_d_ff(code_fd),
    .i_exception_code_e_m_ff(code_em),
    .i_mret_e               (mret),
    .i_irq_ext              (irq),
    .i_mtvec                (mtvec),
    .i_mepc                 (mepc),
    .i_mie                  (mie),
    .i_mstatus_lower        (mstatus),
    .o_flush_f_d            (flush_f_d),
    .o_flush_d_e            (flush_d_e),
    .o_flush_e_m            (flush_e_m),
    .o_stall_f              (stall_f),
    .o_redirect_valid       (rv),
    .o_redirect_pc          (rpc),
    .o_trap_taken           (trap),
    .o_irq_ack              (ack),
    .o_busy                 (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          flush;
    logic          stall;
    logic          busy;
    logic          rv;
    logic [PW-1:0] pc;
    logic          trap;
    logic          ack;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: on an accepted event, lay out the whole per-edge output timeline.
  task automatic model_step();
    bit   em, fd, irq_ok, vect;
    exp_t e;
    logic [PW-1:0] tgt;
    if (!clk_en) return;
    if (q.size() > 0) begin
      cur = q.pop_front();
      return;
    end
    em     = (code_em != `NO_E);
    fd     = (code_fd != `NO_E);
    irq_ok = irq && mie[11] && mstatus[3];
    if (!(em || fd || mret || irq_ok)) begin
      cur = '0;
      return;
    end
    vect = 1'b0;
`ifdef TRAP_VECTORED_EN
    vect = (mtvec[1:0] == 2'b01);
`endif
    if (em || fd) tgt = mtvec & ~32'h3;
    else if (mret) tgt = mepc;
    else tgt = (mtvec & ~32'h3) + (vect ? 32'd44 : 32'd0);
    e = '0; e.flush = 1'b1; e.stall = 1'b1; e.busy = 1'b1;
    cur = e;
    cur.trap = em || fd || !mret;
    cur.ack  = !(em || fd || mret);
    for (int i = 1; i < FC; i++) q.push_back(e);
    e = '0; e.busy = 1'b1; e.rv = 1'b1; e.pc = tgt;
    q.push_back(e);
    q.push_back('0);
  endtask

  task automatic check_outputs();
    check_val("flush_f_d", 32'(flush_f_d), 32'(cur.flush));
    check_val("flush_d_e", 32'(flush_d_e), 32'(cur.flush));
    check_val("flush_e_m", 32'(flush_e_m), 32'(cur.flush));
    check_val("stall_f", 32'(stall_f), 32'(cur.stall));
    check_val("busy", 32'(busy), 32'(cur.busy));
    check_val("redirect_valid", 32'(rv), 32'(cur.rv));
    check_val("redirect_pc", rpc, cur.pc);
    check_val("trap_taken", 32'(trap), 32'(cur.trap));
    check_val("irq_ack", 32'(ack), 32'(cur.ack));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cur = '0;
    end else begin
      model_step();
    end
    #1;
    check_outputs();
  endtask

  task automatic clear_events();
    code_fd = `NO_E;
    code_em = `NO_E;
    mret    = 1'b0;
    irq     = 1'b0;
  endtask

  // Advance until a redirect strobe appears; n = max_cyc means it never came.
  task automatic run_until_redirect(input int max_cyc, output int n, output logic [PW-1:0] pc);
    n  = 0;
    pc = '0;
    while (n < max_cyc) begin
      run_cycle();
      n++;
      if (rv) begin
        pc = rpc;
        break;
      end
    end
  endtask

  int            n;
  logic [PW-1:0] pc;
  logic [PW-1:0] exp_irq_pc;

  initial begin
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    clear_events();
    mtvec   = 32'h0000_0103;
    mepc    = 32'h0000_0240;
    mie     = 32'h0;
    mstatus = 32'h0;
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    run_cycle();

    // E/M exception
    code_em = 4'd5;
    run_cycle();
    check_val("em_trap_pulse", 32'(trap), 32'd1);
    clear_events();
    run_until_redirect(10, n, pc);
    check_val("em_latency", 32'(n), 32'(FC));
    check_val("em_target", pc, 32'h0000_0100);
    run_cycle();

    // mret
    mret = 1'b1;
    run_cycle();
    check_val("mret_no_trap", 32'(trap), 32'd0);
    clear_events();
    run_until_redirect(10, n, pc);
    check_val("mret_target", pc, 32'h0000_0240);
    run_cycle();

    // priority plus F/D exception raised during DRAIN
    code_em = 4'd5; code_fd = 4'd2; mret = 1'b1;
    run_cycle();
    clear_events();
    code_fd = 4'd3;
    run_cycle();
    clear_events();
    run_until_redirect(10, n, pc);
    check_val("prio_target", pc, 32'h0000_0100);
    run_cycle();
    run_cycle();
    check_val("fd_in_drain_ignored", 32'(busy), 32'd0);

    // interrupt gating
    mtvec = 32'h0000_0101;
    irq = 1'b1; mstatus = 32'h8;
    for (int i = 0; i < 3; i++) run_cycle();
    check_val("irq_gated", 32'(busy), 32'd0);
    mie = 32'h800;
    run_cycle();
    check_val("irq_ack_pulse", 32'(ack), 32'd1);
    clear_events();
    run_until_redirect(10, n, pc);
    exp_irq_pc = 32'h0000_0100;
`ifdef TRAP_VECTORED_EN
    exp_irq_pc = 32'h0000_012C;
`endif
    check_val("irq_target", pc, exp_irq_pc);
    run_cycle();

    // clock enable freeze in DRAIN
    code_em = 4'd1;
    run_cycle();
    clear_events();
    run_cycle();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
    clk_en = 1'b1;
    run_until_redirect(20, n, pc);
    check_val("clk_en_latency", 32'(n + 4), 32'(FC + 3));
    run_cycle();

    // async reset mid-DRAIN
    code_em = 4'd7;
    run_cycle();
    clear_events();
    rst_n = 1'b0;
    #1;
    q.delete();
    cur = '0;
    check_outputs();
    run_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle();
    check_val("no_redirect_after_reset", 32'(rv), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clk_en  = ($urandom_range(0, 9) != 0);
      code_em = ($urandom_range(0, 9) < 8) ? `NO_E : 4'($urandom_range(0, 14));
      code_fd = ($urandom_range(0, 9) < 8) ? `NO_E : 4'($urandom_range(0, 14));
      mret    = ($urandom_range(0, 9) == 0);
      irq     = ($urandom_range(0, 3) == 0);
      mie     = $urandom();
      mstatus = $urandom();
      mtvec   = $urandom();
      mepc    = $urandom();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        q.delete();
        cur = '0;
        check_outputs();
      end else begin
        rst_n = 1'b1;
      end
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_redirect_seq.md
Name: trap_redirect_seq

Overview:
- Consumer side of the machine CSR file: reads mtvec/mepc/mie/mstatus and the pipeline exception/mret strobes.
- Sequences the pipeline response: flushes stage registers, stalls fetch, then issues a single-cycle PC redirect to the trap vector (exception/interrupt) or to mepc (mret).
- Sits between the CSR file, the hazard unit and the fetch-stage PC mux.

Parameters:
- FLUSH_CYCLES, 2, number of DRAIN cycles holding flush/stall before redirect; legal range 1..15.
- PC_W, 32, width of PC and CSR inputs.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clk_en  input  1  global clock enable; when low, all state and outputs hold.
- i_exception_code_f_d_ff  input  4  F/D-stage exception code; `NO_E = none.
- i_exception_code_e_m_ff  input  4  E/M-stage exception code; `NO_E = none.
- i_mret_e  input  1  mret in execute.
- i_irq_ext  input  1  level machine external interrupt request.
- i_mtvec  input  PC_W  trap vector CSR.
- i_mepc  input  PC_W  exception PC CSR.
- i_mie  input  PC_W  mie CSR; bit 11 = MEIE.
- i_mstatus_lower  input  PC_W  mstatus; bit 3 = MIE.
- o_flush_f_d  output  1  flush F/D register.
- o_flush_d_e  output  1  flush D/E register.
- o_flush_e_m  output  1  flush E/M register.
- o_stall_f  output  1  hold fetch PC.
- o_redirect_valid  output  1  one-cycle redirect strobe.
- o_redirect_pc  output  PC_W  redirect target; valid only with o_redirect_valid.
- o_trap_taken  output  1  one-cycle pulse on exception/interrupt entry.
- o_irq_ack  output  1  one-cycle pulse when an interrupt is accepted.
- o_busy  output  1  high in DRAIN and REDIRECT.

Behaviour:
- All outputs are registered. Reset (async, i_rst_n=0) forces state IDLE, counter 0, captured target 0, and every output 0.
- FSM states: IDLE, DRAIN, REDIRECT.
- IDLE: evaluate events on each enabled edge, priority highest first:
  1. E/M exception (code != `NO_E)
  2. F/D exception
  3. i_mret_e
  4. interrupt: i_irq_ext & i_mie[11] & i_mstatus_lower[3]
- IDLE with any event: go to DRAIN.
  - Counter loads FLUSH_CYCLES-1.
  - Target captured: {i_mtvec[PC_W-1:2],2'b00} for exception/interrupt; i_mepc for mret.
  - Same edge: o_trap_taken=1 for exception or interrupt; o_irq_ack=1 for interrupt only; both 0 for mret.
- DRAIN: o_flush_f_d, o_flush_d_e, o_flush_e_m, o_stall_f and o_busy all 1. Counter decrements each enabled cycle; at 0, go to REDIRECT.
- REDIRECT: for one cycle, o_redirect_valid=1 and o_redirect_pc=target; flushes drop to 0; o_stall_f=0; o_busy=1. Next state: IDLE.
- Latency: event sampled at edge t. DRAIN occupies cycles t+1..t+FLUSH_CYCLES. Redirect is at cycle t+FLUSH_CYCLES+1. Next event is accepted at edge t+FLUSH_CYCLES+2.
- Events arriving in DRAIN/REDIRECT are ignored; they come from flushed stages.
- A level interrupt still asserted after return is re-evaluated in IDLE. The CSR file has cleared mie on trap entry, so there is no re-entry until software restores it.
- Simultaneous E/M and F/D exceptions: a single trap is taken, with the same mtvec target. Cause recording is the CSR file's job.
- i_clk_en=0 in any state: freeze state, counter and outputs. A pulse output stays high while frozen and is observed once.
- Reset asserted mid-DRAIN/REDIRECT: immediate return to IDLE with all outputs 0. No redirect is issued.
- o_redirect_pc is 0 outside REDIRECT.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when i_mtvec[1:0]==2'b01 and the event is an interrupt, target = {i_mtvec[PC_W-1:2],2'b00} + 44 (cause 11 × 4). Exceptions always use the base address.
- Undefined: mode bits are ignored; all traps use the base address.

Test Plan:
- Reset: i_rst_n=0 mid-DRAIN -> all outputs 0 asynchronously; state IDLE; no redirect after release.
- E/M exception: code 4'd5, mtvec=0x0000_0103, FLUSH_CYCLES=2 -> o_trap_taken pulse at t; flushes+stall at t+1,t+2; o_redirect_valid with pc 0x0000_0100 at t+3.
- mret: i_mret_e=1, i_mepc=0x0000_0240 -> no o_trap_taken; 2 DRAIN cycles; redirect pc 0x0000_0240.
- Priority: E/M exception, F/D exception and mret in the same cycle -> single trap to mtvec base; F/D exception raised during DRAIN is ignored.
- Interrupt gating: i_irq_ext=1 with i_mie[11]=0 -> no action; set mie[11]=1 and mstatus[3]=1 -> o_irq_ack pulse; redirect to 0x100 (or 0x12C with TRAP_VECTORED_EN and mtvec=0x101).
- Clock enable: i_clk_en=0 for 3 cycles during DRAIN -> outputs frozen; redirect delayed by exactly 3 cycles.
